sram_bus_arbiter: RTL and testbench

Two-to-one arbiter sharing the single data-side SRAM-like bus between the instruction-fetch requester (IF stage) and the load/store requester (EX issue, MEM return). It forwards one request per cycle onto the bus using the req/addr_ok/data_ok protocol. It holds a granted request stable until the bus accepts it. It tracks outstanding transactions in order and routes each returning data_ok/rdata back to the requester that issued it.

---
 rtl/sram_bus_arbiter_pkg.sv | 22 ++
 rtl/sram_arb_id_fifo.sv | 64 ++++++
 rtl/sram_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_sram_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the SRAM bus arbiter: requester source ids, access sizes and lock states.
package sram_bus_arbiter_pkg;

  localparam logic ARB_SRC_INST = 1'b0;
  localparam logic ARB_SRC_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_INST = 2'd1,
    LOCK_DATA = 2'd2
  } lock_state_e;

  // A depth-1 FIFO still needs a one-bit pointer to stay legal.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sram_arb_id_fifo.sv
// In-order FIFO of 1-bit source ids for accepted-but-unanswered bus transactions.
module sram_arb_id_fifo
  import sram_bus_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic push_src,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] src_mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_en;
  logic             pop_en;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = src_mem[rd_ptr];
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (push_en) begin
      src_mem[wr_ptr] <= push_src;
    end
  end

  // Simultaneous push and pop leaves the occupancy unchanged.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop_en) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Two-to-one arbiter sharing one SRAM-like bus between instruction fetch and load/store.
// Optional macro SRAM_ARB_ROUND_ROBIN_EN: alternate winners on contention instead of data-first.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,

  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [31:0]       bus_rdata
);

  lock_state_e lock_state;
  logic        sel_data;
  logic        sel_req;
  logic        contend_pick_data;
  logic        accept;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_head;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_winner;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_winner <= ARB_SRC_INST;
    end else if (accept) begin
      last_winner <= sel_data ? ARB_SRC_DATA : ARB_SRC_INST;
    end
  end

  assign contend_pick_data = (last_winner == ARB_SRC_INST);
`else
  assign contend_pick_data = 1'b1;
`endif

  // A locked grantee keeps the bus until accepted, regardless of the other side.
  always_comb begin
    sel_data = 1'b0;
    case (lock_state)
      LOCK_INST: sel_data = 1'b0;
      LOCK_DATA: sel_data = 1'b1;
      default: begin
        if (inst_req && data_req) begin
          sel_data = contend_pick_data;
        end else begin
          sel_data = data_req;
        end
      end
    endcase
  end

  assign sel_req = sel_data ? data_req : inst_req;
  assign bus_req = sel_req & ~fifo_full;
  assign accept  = bus_req & bus_addr_ok;

  always_comb begin
    bus_wr    = 1'b0;
    bus_size  = 2'd0;
    bus_wstrb = 4'd0;
    bus_addr  = '0;
    bus_wdata = 32'd0;
    if (bus_req) begin
      if (sel_data) begin
        bus_wr    = data_wr;
        bus_size  = data_size;
        bus_wstrb = data_wstrb;
        bus_addr  = data_addr;
        bus_wdata = data_wdata;
      end else begin
        bus_size  = SIZE_WORD;
        bus_addr  = inst_addr;
      end
    end
  end

  assign inst_addr_ok = accept & ~sel_data;
  assign data_addr_ok = accept & sel_data;

  // A response with nothing outstanding is dropped rather than routed.
  assign pop          = bus_data_ok & ~fifo_empty;
  assign inst_data_ok = pop & (fifo_head == ARB_SRC_INST);
  assign data_data_ok = pop & (fifo_head == ARB_SRC_DATA);
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_state <= LOCK_NONE;
    end else if (accept) begin
      lock_state <= LOCK_NONE;
    end else if (bus_req) begin
      lock_state <= sel_data ? LOCK_DATA : LOCK_INST;
    end
  end

  sram_arb_id_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (accept),
    .push_src(sel_data ? ARB_SRC_DATA : ARB_SRC_INST),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Table-driven bench for sram_bus_arbiter with an in-order scoreboard of response owners.
module tb_sram_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam logic [31:0] IA0 = 32'h1c00_0000;
  localparam logic [31:0] IA1 = 32'h1c00_0010;
  localparam logic [31:0] IA2 = 32'h1c00_0020;
  localparam logic [31:0] DA0 = 32'h0000_1000;
  localparam logic [31:0] DA1 = 32'h0000_2000;
  localparam logic [31:0] DA2 = 32'h0000_3000;
  localparam logic [31:0] STORE_WDATA = 32'hcafe_0011;

  typedef enum logic [1:0] {G_NONE, G_INST, G_DATA} grant_e;

  typedef struct {
    string       name;
    logic        rstn;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwr;
    logic [1:0]  dsize;
    logic [3:0]  dstrb;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    grant_e      grant;
  } vec_t;

  logic              clk;
  logic              resetn;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [31:0]       inst_rdata;
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [3:0]        data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;
  logic              bus_req;
  logic              bus_wr;
  logic [1:0]        bus_size;
  logic [3:0]        bus_wstrb;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [31:0]       bus_rdata;

  int   errors = 0;
  int   checks = 0;
  logic exp_src_q[$];
  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_bus_arbiter #(
    .OUTSTANDING(2),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_wstrb  (data_wstrb),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_size    (bus_size),
    .bus_wstrb   (bus_wstrb),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata)
  );

  // Stores are half-word writes of the low two bytes; loads are full words.
  function automatic vec_t mk(input string nm, input logic ireq, input logic [31:0] iaddr,
                              input logic dreq, input logic dwr, input logic [31:0] daddr,
                              input logic aok, input logic dok, input logic [31:0] rdata,
                              input grant_e g);
    vec_t t;
    t.name   = nm;
    t.rstn   = 1'b1;
    t.ireq   = ireq;
    t.iaddr  = ireq ? iaddr : 32'd0;
    t.dreq   = dreq;
    t.dwr    = dreq & dwr;
    t.dsize  = !dreq ? 2'd0 : (dwr ? 2'd1 : 2'd2);
    t.dstrb  = (dreq && dwr) ? 4'b0011 : 4'b0000;
    t.daddr  = dreq ? daddr : 32'd0;
    t.dwdata = (dreq && dwr) ? STORE_WDATA : 32'd0;
    t.aok    = aok;
    t.dok    = dok;
    t.rdata  = rdata;
    t.grant  = g;
    return t;
  endfunction

  task automatic compareField(input string rowName, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", rowName, field, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    resetn      = t.rstn;
    inst_req    = t.ireq;
    inst_addr   = t.iaddr;
    data_req    = t.dreq;
    data_wr     = t.dwr;
    data_size   = t.dsize;
    data_wstrb  = t.dstrb;
    data_addr   = t.daddr;
    data_wdata  = t.dwdata;
    bus_addr_ok = t.aok;
    bus_data_ok = t.dok;
    bus_rdata   = t.rdata;
  endtask

  task automatic checkOutput(input vec_t t);
    logic        e_req;
    logic        e_wr;
    logic [1:0]  e_size;
    logic [3:0]  e_strb;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_iok;
    logic        e_dok;
    logic        e_idata;
    logic        e_ddata;
    logic        src;
    e_req   = (t.grant != G_NONE);
    e_wr    = (t.grant == G_DATA) ? t.dwr : 1'b0;
    e_size  = (t.grant == G_DATA) ? t.dsize : ((t.grant == G_INST) ? 2'd2 : 2'd0);
    e_strb  = (t.grant == G_DATA) ? t.dstrb : 4'd0;
    e_addr  = (t.grant == G_DATA) ? t.daddr : ((t.grant == G_INST) ? t.iaddr : 32'd0);
    e_wdata = (t.grant == G_DATA) ? t.dwdata : 32'd0;
    e_iok   = (t.grant == G_INST) && t.aok;
    e_dok   = (t.grant == G_DATA) && t.aok;
    e_idata = 1'b0;
    e_ddata = 1'b0;
    if (t.dok && exp_src_q.size() > 0) begin
      src = exp_src_q.pop_front();
      e_idata = ~src;
      e_ddata = src;
    end
    compareField(t.name, "bus_req", 32'(bus_req), 32'(e_req));
    compareField(t.name, "bus_addr", bus_addr, e_addr);
    compareField(t.name, "bus_wr", 32'(bus_wr), 32'(e_wr));
    compareField(t.name, "bus_size", 32'(bus_size), 32'(e_size));
    compareField(t.name, "bus_wstrb", 32'(bus_wstrb), 32'(e_strb));
    compareField(t.name, "bus_wdata", bus_wdata, e_wdata);
    compareField(t.name, "inst_addr_ok", 32'(inst_addr_ok), 32'(e_iok));
    compareField(t.name, "data_addr_ok", 32'(data_addr_ok), 32'(e_dok));
    compareField(t.name, "inst_data_ok", 32'(inst_data_ok), 32'(e_idata));
    compareField(t.name, "data_data_ok", 32'(data_data_ok), 32'(e_ddata));
    compareField(t.name, "inst_rdata", inst_rdata, t.rdata);
    compareField(t.name, "data_rdata", data_rdata, t.rdata);
    if (e_iok) exp_src_q.push_back(1'b0);
    if (e_dok) exp_src_q.push_back(1'b1);
    if (!t.rstn) exp_src_q.delete();
  endtask

  task automatic runRow(input vec_t t);
    applyStimulus(t);
    @(negedge clk);
    checkOutput(t);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t t;
    grant_e rr_pair;

    applyStimulus(mk("init", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, G_NONE));
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    rr_pair = G_INST;
`else
    rr_pair = G_DATA;
`endif

    t = mk("reset_idle", 0, 0, 0, 0, 0, 0, 0, 32'h0, G_NONE); t.rstn = 1'b0; vecs.push_back(t);
    vecs.push_back(mk("fetch_acc",   1, IA0, 0, 0, 0,   1, 0, 32'h0,         G_INST));
    vecs.push_back(mk("fetch_wait",  0, 0,   0, 0, 0,   0, 0, 32'h0,         G_NONE));
    vecs.push_back(mk("fetch_resp",  0, 0,   0, 0, 0,   0, 1, 32'h02800c0c,  G_NONE));
    vecs.push_back(mk("cont_data",   1, IA1, 1, 1, DA0, 1, 0, 32'h0,         G_DATA));
    vecs.push_back(mk("cont_inst",   1, IA1, 0, 0, 0,   1, 0, 32'h0,         G_INST));
    vecs.push_back(mk("cont_rsp0",   0, 0,   0, 0, 0,   0, 1, 32'h0000_0011, G_NONE));
    vecs.push_back(mk("cont_rsp1",   0, 0,   0, 0, 0,   0, 1, 32'h0000_0022, G_NONE));
    vecs.push_back(mk("pair2",       1, IA2, 1, 0, DA1, 1, 0, 32'h0,         G_DATA));
    vecs.push_back(mk("pair3",       1, IA2, 1, 0, DA1, 1, 0, 32'h0,         rr_pair));
    vecs.push_back(mk("pair_rsp0",   0, 0,   0, 0, 0,   0, 1, 32'h0000_0044, G_NONE));
    vecs.push_back(mk("pair_rsp1",   0, 0,   0, 0, 0,   0, 1, 32'h0000_0055, G_NONE));
    vecs.push_back(mk("lock_c0",     1, IA1, 0, 0, 0,   0, 0, 32'h0,         G_INST));
    vecs.push_back(mk("lock_c1",     1, IA1, 1, 0, DA1, 0, 0, 32'h0,         G_INST));
    vecs.push_back(mk("lock_c2",     1, IA1, 1, 0, DA1, 0, 0, 32'h0,         G_INST));
    vecs.push_back(mk("lock_c3_acc", 1, IA1, 1, 0, DA1, 1, 0, 32'h0,         G_INST));
    vecs.push_back(mk("lock_data",   0, 0,   1, 0, DA1, 1, 0, 32'h0,         G_DATA));
    vecs.push_back(mk("full_block",  1, IA2, 0, 0, 0,   1, 0, 32'h0,         G_NONE));
    vecs.push_back(mk("full_pop",    1, IA2, 0, 0, 0,   1, 1, 32'h0000_0066, G_NONE));
    vecs.push_back(mk("full_acc",    1, IA2, 0, 0, 0,   1, 0, 32'h0,         G_INST));
    vecs.push_back(mk("drain0",      0, 0,   0, 0, 0,   0, 1, 32'h0000_0077, G_NONE));
    vecs.push_back(mk("drain1",      0, 0,   0, 0, 0,   0, 1, 32'h0000_0088, G_NONE));
    vecs.push_back(mk("ord_d0",      0, 0,   1, 1, DA0, 1, 0, 32'h0,         G_DATA));
    vecs.push_back(mk("ord_i1",      1, IA0, 0, 0, 0,   1, 0, 32'h0,         G_INST));
    vecs.push_back(mk("ord_popfull", 0, 0,   1, 0, DA2, 1, 1, 32'h0000_0101, G_NONE));
    vecs.push_back(mk("ord_d2",      0, 0,   1, 0, DA2, 1, 0, 32'h0,         G_DATA));
    vecs.push_back(mk("ord_rsp1",    0, 0,   0, 0, 0,   0, 1, 32'h0000_0202, G_NONE));
    vecs.push_back(mk("ord_rsp2",    0, 0,   0, 0, 0,   0, 1, 32'h0000_0303, G_NONE));
    vecs.push_back(mk("empty_rsp",   0, 0,   0, 0, 0,   0, 1, 32'h0000_0404, G_NONE));
    vecs.push_back(mk("rst_i",       1, IA0, 0, 0, 0,   1, 0, 32'h0,         G_INST));
    vecs.push_back(mk("rst_d",       0, 0,   1, 0, DA0, 1, 0, 32'h0,         G_DATA));
    t = mk("rst_pulse", 0, 0, 0, 0, 0, 0, 0, 32'h0, G_NONE); t.rstn = 1'b0; vecs.push_back(t);
    vecs.push_back(mk("rst_stale",   0, 0,   1, 0, DA2, 1, 1, 32'h0000_0505, G_DATA));
    vecs.push_back(mk("rst_new_rsp", 0, 0,   0, 0, 0,   0, 1, 32'h0000_0606, G_NONE));

    foreach (vecs[i]) begin
      runRow(vecs[i]);
    end

    // Data-side lock: inst asserting mid-stall must not steal the bus.
    runRow(mk("dlock_c0",  0, 0,   1, 0, DA2, 0, 0, 32'h0,         G_DATA));
    runRow(mk("dlock_c1",  1, IA2, 1, 0, DA2, 0, 0, 32'h0,         G_DATA));
    runRow(mk("dlock_acc", 1, IA2, 1, 0, DA2, 1, 0, 32'h0,         G_DATA));
    runRow(mk("dlock_inst",1, IA2, 0, 0, 0,   1, 0, 32'h0,         G_INST));
    runRow(mk("dlock_r0",  0, 0,   0, 0, 0,   0, 1, 32'h0000_0707, G_NONE));
    runRow(mk("dlock_r1",  0, 0,   0, 0, 0,   0, 1, 32'h0000_0808, G_NONE));
    runRow(mk("final_idle",0, 0,   0, 0, 0,   0, 0, 32'h0,         G_NONE));

    checks++;
    if (exp_src_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_src_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
